// File: rtl/write_buffer.sv
// Write-through store buffer: circular FIFO drained to main memory by a two-state FSM,
// with youngest-match read forwarding. Define WB_COALESCE_EN to merge stores to queued addresses.
module write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrReq,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  output logic                     wrAccept,
  input  logic [ADDR_W-1:0]        lookupAddr,
  output logic                     lookupHit,
  output logic [DATA_W-1:0]        lookupData,
  output logic [ADDR_W-1:0]        memAddr,
  output logic [DATA_W-1:0]        memWriteData,
  output logic                     memWrite,
  input  logic                     memDone,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  state_t            state_reg;

  logic [DEPTH-1:0]  lookup_match;
  logic [PTR_W-1:0]  lk_idx;
  logic              full;
  logic              push;
  logic              pop;
  logic              coal_hit;
  logic              coal_wr;
  logic [PTR_W-1:0]  coal_idx;
  logic [DATA_W-1:0] head_data;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lookup
      assign lookup_match[gi] = valid_reg[gi] && (addr_mem[gi] == lookupAddr);
    end
  endgenerate

`ifdef WB_COALESCE_EN
  logic [DEPTH-1:0] wr_match;
  logic [PTR_W-1:0] wr_idx;

  // The head is off limits once its write is on the memory bus.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_coal
      assign wr_match[gi] = valid_reg[gi] && (addr_mem[gi] == wrAddr) &&
                            !(state_reg == ISSUE && head_reg == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    wr_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      wr_idx = head_reg + PTR_W'(k);
      if (wr_match[wr_idx]) begin
        coal_hit = 1'b1;
        coal_idx = wr_idx;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  // Walk oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    lk_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_reg + PTR_W'(k);
      if (lookup_match[lk_idx]) begin
        lookupHit  = 1'b1;
        lookupData = data_mem[lk_idx];
      end
    end
  end

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign wrAccept  = !full || coal_hit;
  assign coal_wr   = wrReq && coal_hit;
  assign push      = wrReq && wrAccept && !coal_hit;
  assign pop       = (state_reg == ISSUE) && memDone;
  assign empty     = (count_reg == '0) && (state_reg == IDLE);
  assign count     = count_reg;
  // A store merging into the head on the issue edge must reach the bus with its new data.
  assign head_data = (coal_wr && coal_idx == head_reg) ? wrData : data_mem[head_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= wrAddr;
      data_mem[tail_reg] <= wrData;
    end
    if (coal_wr) begin
      data_mem[coal_idx] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // Push and pop never target the same slot: that needs full with push, or empty with pop.
      for (int k = 0; k < DEPTH; k++) begin
        if (push && tail_reg == PTR_W'(k)) valid_reg[k] <= 1'b1;
        else if (pop && head_reg == PTR_W'(k)) valid_reg[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      memWrite     <= 1'b0;
      memAddr      <= '0;
      memWriteData <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            state_reg    <= ISSUE;
            memWrite     <= 1'b1;
            memAddr      <= addr_mem[head_reg];
            memWriteData <= head_data;
          end
        end
        ISSUE: begin
          if (memDone) begin
            state_reg <= IDLE;
            memWrite  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: reset, drain handshake, full/refuse, forwarding,
// pop-with-push-when-full, reset mid-issue and the coalescing configuration.
module tb_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wrReq;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrAccept;
  logic [ADDR_W-1:0] lookupAddr;
  logic              lookupHit;
  logic [DATA_W-1:0] lookupData;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWriteData;
  logic              memWrite;
  logic              memDone;
  logic              empty;
  logic [2:0]        count;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] dq_addr [$];
  logic [DATA_W-1:0] dq_data [$];

  write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrReq        (wrReq),
    .wrAddr       (wrAddr),
    .wrData       (wrData),
    .wrAccept     (wrAccept),
    .lookupAddr   (lookupAddr),
    .lookupHit    (lookupHit),
    .lookupData   (lookupData),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .memDone      (memDone),
    .empty        (empty),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wrReq  = 1'b1;
    wrAddr = a;
    wrData = d;
    tick();
    wrReq  = 1'b0;
  endtask

  task automatic wait_memwrite(input string tag);
    int budget = 0;
    while (!memWrite && budget < 8) begin
      tick();
      budget++;
    end
    check(tag, memWrite, 1'b1);
  endtask

  // Acknowledge every issued write and log what went out, until the buffer is empty.
  task automatic drain(input string tag);
    int budget = 0;
    dq_addr.delete();
    dq_data.delete();
    while (!empty && budget < 60) begin
      if (memWrite) begin
        dq_addr.push_back(memAddr);
        dq_data.push_back(memWriteData);
        memDone = 1'b1;
      end else begin
        memDone = 1'b0;
      end
      tick();
      budget++;
    end
    memDone = 1'b0;
    check(tag, empty, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    wrReq      = 1'b0;
    wrAddr     = '0;
    wrData     = '0;
    lookupAddr = '0;
    memDone    = 1'b0;

    // Reset values, before any clock edge
    #2;
    check("rst_count",    count, 0);
    check("rst_waccept",  wrAccept, 1);
    check("rst_empty",    empty, 1);
    check("rst_memwrite", memWrite, 0);
    check("rst_memaddr",  memAddr, 0);
    check("rst_memdata",  memWriteData, 0);
    check("rst_hit",      lookupHit, 0);
    check("rst_ldata",    lookupData, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single store and drain handshake
    push(32'h0000_0000, 32'hF0F0_F0F0);
    check("t1_count", count, 1);
    wait_memwrite("t1_memwrite");
    check("t1_memaddr", memAddr, 32'h0);
    check("t1_memdata", memWriteData, 32'hF0F0_F0F0);
    memDone = 1'b1;
    tick();
    memDone = 1'b0;
    check("t1_count_after", count, 0);
    check("t1_empty", empty, 1);
    check("t1_memwrite_off", memWrite, 0);

    // Fill, refuse, then one pop reopens
    for (int i = 0; i < 4; i++) push(32'(4 * i), 32'hA0 + 32'(i));
    check("t2_count_full", count, 4);
    wrReq  = 1'b1;
    wrAddr = 32'h10;
    wrData = 32'hEE;
    #1;
    check("t2_waccept_full", wrAccept, 0);
    tick();
    wrReq = 1'b0;
    check("t2_count_refused", count, 4);
    check("t2_issue_addr", memAddr, 32'h0);
    memDone = 1'b1;
    tick();
    memDone = 1'b0;
    check("t2_count_pop", count, 3);
    check("t2_waccept_pop", wrAccept, 1);
    drain("t2_drain");
    check("t2_drain_n", dq_addr.size(), 3);
    if (dq_addr.size() == 3) begin
      check("t2_drain_a0", dq_addr[0], 32'h4);
      check("t2_drain_d0", dq_data[0], 32'hA1);
      check("t2_drain_a2", dq_addr[2], 32'hC);
      check("t2_drain_d2", dq_data[2], 32'hA3);
    end

    // Forwarding picks the youngest match
    push(32'h100, 32'h1);
    push(32'h100, 32'h2);
    lookupAddr = 32'h100;
    #1;
    check("t3_hit", lookupHit, 1);
    check("t3_data", lookupData, 32'h2);
    lookupAddr = 32'h104;
    #1;
    check("t3_miss_hit", lookupHit, 0);
    check("t3_miss_data", lookupData, 0);
`ifdef WB_COALESCE_EN
    check("t3_count", count, 1);
`else
    check("t3_count", count, 2);
`endif
    drain("t3_drain");

    // Full buffer: pop and push in the same cycle, push refused
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
    wait_memwrite("t4_memwrite");
    memDone = 1'b1;
    wrReq   = 1'b1;
    wrAddr  = 32'h300;
    wrData  = 32'hDEAD;
    #1;
    check("t4_waccept", wrAccept, 0);
    tick();
    memDone = 1'b0;
    wrReq   = 1'b0;
    check("t4_count", count, 3);
    drain("t4_drain");
    check("t4_drain_n", dq_addr.size(), 3);
    if (dq_addr.size() == 3) begin
      check("t4_drain_a0", dq_addr[0], 32'h204);
      check("t4_drain_a2", dq_addr[2], 32'h20C);
    end

    // Store to a queued address on a full buffer
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 32'hC0 + 32'(i));
    wait_memwrite("t5_memwrite");
    wrReq  = 1'b1;
    wrAddr = 32'h408;
    wrData = 32'h5555;
    #1;
`ifdef WB_COALESCE_EN
    check("t5_waccept", wrAccept, 1);
`else
    check("t5_waccept", wrAccept, 0);
`endif
    tick();
    wrReq = 1'b0;
    check("t5_count", count, 4);
    drain("t5_drain");
    check("t5_drain_n", dq_addr.size(), 4);
    if (dq_addr.size() == 4) begin
      check("t5_drain_a2", dq_addr[2], 32'h408);
`ifdef WB_COALESCE_EN
      check("t5_drain_d2", dq_data[2], 32'h5555);
`else
      check("t5_drain_d2", dq_data[2], 32'hC2);
`endif
    end

    // Reset during ISSUE abandons everything; late memDone is ignored
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 32'hD0 + 32'(i));
    wait_memwrite("t6_memwrite");
    lookupAddr = 32'h500;
    rst = 1'b0;
    #1;
    check("t6_memwrite_rst", memWrite, 0);
    check("t6_count_rst", count, 0);
    check("t6_empty_rst", empty, 1);
    check("t6_waccept_rst", wrAccept, 1);
    check("t6_hit_rst", lookupHit, 0);
    tick();
    rst     = 1'b1;
    memDone = 1'b1;
    tick();
    memDone = 1'b0;
    check("t6_count_late", count, 0);
    check("t6_memwrite_late", memWrite, 0);
    push(32'h600, 32'h77);
    check("t6_count_new", count, 1);
    drain("t6_drain");
    check("t6_drain_n", dq_addr.size(), 1);
    if (dq_addr.size() == 1) begin
      check("t6_drain_a", dq_addr[0], 32'h600);
      check("t6_drain_d", dq_data[0], 32'h77);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
